// File: rtl/core_pkg.sv
// Shared RV32I core definitions: PC-select encodings, the canonical NOP and the reset vector.
package core_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_e;

    // Only the two target selects redirect; the reserved code falls back to PC+4.
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == PCSRC_BRANCH) || (sel == PCSRC_JALR);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational-read ROM.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output addr, input rdata);
    modport slave  (input addr, output rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline stage register (instr, pc, pc+4, valid) with flush-over-stall priority.
module if_id_reg
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] instr_f,
    input  logic [DATA_WIDTH-1:0] pc_f,
    input  logic [DATA_WIDTH-1:0] pcplus4_f,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pcplus4_d,
    output logic                  valid_d
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d   <= DATA_WIDTH'(NOP_INSTR);
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (flush) begin
            // A bubble must look like a harmless addi x0,x0,0 downstream.
            instr_d   <= DATA_WIDTH'(NOP_INSTR);
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (!stall) begin
            instr_d   <= instr_f;
            pc_d      <= pc_f;
            pcplus4_d <= pcplus4_f;
            valid_d   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline register.
module fetch_stage
    import core_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_f,
    input  logic                  flush_d,
    input  logic [1:0]            pcsrc,
    input  logic [DATA_WIDTH-1:0] pc_target,
    input  logic [DATA_WIDTH-1:0] jalr_target,
    fetch_stage_if.master         imem,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pcplus4_d,
    output logic                  valid_d,
    output logic                  misalign_o
);

    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] target_sel;
    logic                  misalign_reg;
    logic                  misalign_next;
    logic                  redirect;

    assign pc_plus4  = pc_reg + DATA_WIDTH'(4);
    assign imem.addr = pc_reg;

    // Redirect beats stall so a taken branch arriving during a load-use stall is not lost.
    always_comb begin
        redirect      = is_redirect(pcsrc);
        target_sel    = (pcsrc == PCSRC_BRANCH) ? pc_target : jalr_target;
        pc_next       = pc_plus4;
        misalign_next = 1'b0;
        if (redirect) begin
            pc_next       = {target_sel[DATA_WIDTH-1:2], 2'b00};
            misalign_next = (target_sel[1:0] != 2'b00);
        end else if (stall_f) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
        end
    end

    assign misalign_o = misalign_reg;

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_d),
        .stall     (stall_f),
        .instr_f   (imem.rdata),
        .pc_f      (pc_reg),
        .pcplus4_f (pc_plus4),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pcplus4_d (pcplus4_d),
        .valid_d   (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model predicts each edge, results are popped after it.
module tb_fetch_stage;
    import core_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_d;
        logic [31:0] pcplus4;
        logic        valid;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f, flush_d;
    logic [1:0]  pcsrc;
    logic [31:0] pc_target, jalr_target;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic        valid_d, misalign_o;

    logic [31:0] w_instr_d, w_pc_d, w_pcplus4_d;
    logic        w_valid_d, w_misalign_o;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    exp_t sb[$];

    logic [31:0] m_pc, m_instr, m_pc_d, m_pcplus4;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    fetch_stage_if #(.DATA_WIDTH(32)) imem_bus ();
    fetch_stage_if #(.DATA_WIDTH(32)) wrap_bus ();
    assign imem_bus.rdata = rom(imem_bus.addr);
    assign wrap_bus.rdata = rom(wrap_bus.addr);

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .flush_d     (flush_d),
        .pcsrc       (pcsrc),
        .pc_target   (pc_target),
        .jalr_target (jalr_target),
        .imem        (imem_bus.master),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d),
        .misalign_o  (misalign_o)
    );

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (1'b0),
        .flush_d     (1'b0),
        .pcsrc       (2'b00),
        .pc_target   (32'h0),
        .jalr_target (32'h0),
        .imem        (wrap_bus.master),
        .instr_d     (w_instr_d),
        .pc_d        (w_pc_d),
        .pcplus4_d   (w_pcplus4_d),
        .valid_d     (w_valid_d),
        .misalign_o  (w_misalign_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC_DEFAULT;
        m_instr   = NOP_INSTR;
        m_pc_d    = 32'h0;
        m_pcplus4 = 32'h0;
        m_valid   = 1'b0;
        m_mis     = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the post-edge state, then compare after the edge.
    task automatic step(input logic s, input logic f, input logic [1:0] ps,
                        input logic [31:0] pt, input logic [31:0] jt);
        exp_t        e;
        logic        redir;
        logic [31:0] tgt;
        stall_f = s; flush_d = f; pcsrc = ps; pc_target = pt; jalr_target = jt;
        redir = (ps == 2'b01) || (ps == 2'b10);
        tgt   = (ps == 2'b01) ? pt : jt;
        if (f) begin
            m_instr = NOP_INSTR; m_pc_d = 32'h0; m_pcplus4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = rom(m_pc); m_pc_d = m_pc; m_pcplus4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_mis = redir && (tgt[1:0] != 2'b00);
        if (redir)   m_pc = {tgt[31:2], 2'b00};
        else if (!s) m_pc = m_pc + 32'd4;
        e.pc = m_pc; e.instr = m_instr; e.pc_d = m_pc_d;
        e.pcplus4 = m_pcplus4; e.valid = m_valid; e.mis = m_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        txn++;
        $display("txn %0d stall=%0b flush=%0b pcsrc=%0d pc=%h instr_d=%h pc_d=%h valid=%0b mis=%0b",
                 txn, s, f, ps, imem_bus.addr, instr_d, pc_d, valid_d, misalign_o);
        check("pc",       imem_bus.addr, e.pc);
        check("instr_d",  instr_d,       e.instr);
        check("pc_d",     pc_d,          e.pc_d);
        check("pcplus4",  pcplus4_d,     e.pcplus4);
        check("valid_d",  {31'h0, valid_d},    {31'h0, e.valid});
        check("misalign", {31'h0, misalign_o}, {31'h0, e.mis});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},      imem_bus.addr, RESET_PC_DEFAULT);
        check({tag, "_instr"},   instr_d,       NOP_INSTR);
        check({tag, "_pc_d"},    pc_d,          32'h0);
        check({tag, "_pcplus4"}, pcplus4_d,     32'h0);
        check({tag, "_valid"},   {31'h0, valid_d},    32'h0);
        check({tag, "_mis"},     {31'h0, misalign_o}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall_f = 1'b0; flush_d = 1'b0; pcsrc = 2'b00;
        pc_target = 32'h0; jalr_target = 32'h0;
        model_reset();
        #22;
        check_reset_outputs("rst");
        check("wrap_rst_pc", wrap_bus.addr, 32'hFFFF_FFF8);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running fetch; also watch the wrap-around instance.
        step(0, 0, 2'b00, 0, 0);
        check("seq0_pc_d", pc_d, 32'hBFC0_0000);
        check("seq0_instr", instr_d, 32'hBFC0_0000 ^ 32'h1357_9BDF);
        check("wrap_pc1", wrap_bus.addr, 32'hFFFF_FFFC);
        step(0, 0, 2'b00, 0, 0);
        check("wrap_pc2", wrap_bus.addr, 32'h0000_0000);
        check("wrap_pcplus4", w_pcplus4_d, 32'h0000_0000);
        step(0, 0, 2'b00, 0, 0);
        check("seq_pc3", imem_bus.addr, 32'hBFC0_000C);
        step(0, 0, 2'b00, 0, 0);

        // Branch redirect with flush, then the target instruction.
        step(0, 1, 2'b01, 32'hBFC0_0040, 0);
        check("br_pc", imem_bus.addr, 32'hBFC0_0040);
        step(0, 0, 2'b00, 0, 0);
        check("br_pc_d", pc_d, 32'hBFC0_0040);

        // jalr misaligned then aligned.
        step(0, 1, 2'b10, 0, 32'hBFC0_0023);
        check("jalr_pc", imem_bus.addr, 32'hBFC0_0020);
        check("jalr_mis", {31'h0, misalign_o}, 32'h1);
        step(0, 0, 2'b00, 0, 0);
        step(0, 1, 2'b10, 0, 32'hBFC0_0020);
        step(0, 0, 2'b00, 0, 0);

        // Three-cycle stall then resume.
        step(1, 0, 2'b00, 0, 0);
        step(1, 0, 2'b00, 0, 0);
        step(1, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);

        // Stall+flush with redirect, stall+flush without, reserved pcsrc.
        step(1, 1, 2'b01, 32'h0000_1002, 0);
        check("sf_pc", imem_bus.addr, 32'h0000_1000);
        step(0, 0, 2'b00, 0, 0);
        step(1, 1, 2'b00, 0, 0);
        step(0, 0, 2'b11, 32'h0000_5000, 32'h0000_6000);

        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 2'b00, 0, 0);
        step(0, 0, 2'b01, 32'h0000_0200, 0);
        step(0, 1, 2'b00, 0, 0);
        step(0, 0, 2'b00, 0, 0);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
